// File: rtl/lock_supervisor.sv
// Bit-serial password lock sequencer: MSB-first entry compare, failure counting,
// lockout window, entry timeout, bounded unlock window and password re-programming.
module lock_supervisor #(
  parameter int unsigned PW_LEN         = 6,
  parameter logic [PW_LEN-1:0] DEFAULT_PW = 6'b111000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10,
  localparam int unsigned FW            = $clog2(MAX_FAIL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              relock,
  input  logic              prog_req,
  input  logic [PW_LEN-1:0] prog_pw,
  output logic              unlocked,
  output logic              locked_out,
  output logic              entry_busy,
  output logic              fail,
  output logic              prog_ack,
  output logic [FW-1:0]     fail_cnt
);

  localparam int unsigned IW    = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam int unsigned TMAX0 = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t            r_state;
  logic [PW_LEN-1:0] r_pw;
  logic [IW-1:0]     r_idx;
  logic              r_mis;
  logic [TW-1:0]     r_timer;

  logic [IW-1:0] w_pos;
  logic          w_bit_mis;
  logic          w_mis_all;
  logic          w_last;
  logic          w_timeout;
  logic          w_eval;
  logic          w_eval_fail;

  // r_idx is 0 outside ENTRY, so the same compare serves the first bit in IDLE
  assign w_pos       = IW'(PW_LEN - 1) - r_idx;
  assign w_bit_mis   = bit_in ^ r_pw[w_pos];
  assign w_mis_all   = r_mis | w_bit_mis;
  assign w_last      = (r_idx == IW'(PW_LEN - 1));
  assign w_timeout   = !bit_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_eval      = (bit_valid && w_last) || w_timeout;
  assign w_eval_fail = bit_valid ? w_mis_all : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pw       <= DEFAULT_PW;
      r_idx      <= '0;
      r_mis      <= 1'b0;
      r_timer    <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      entry_busy <= 1'b0;
      fail       <= 1'b0;
      prog_ack   <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      fail     <= 1'b0;
      prog_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bit_valid) begin
            r_mis      <= w_bit_mis;
            r_idx      <= IW'(1);
            r_timer    <= '0;
            entry_busy <= 1'b1;
            r_state    <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (w_eval) begin
            r_idx      <= '0;
            r_mis      <= 1'b0;
            r_timer    <= '0;
            entry_busy <= 1'b0;
            if (!w_eval_fail) begin
              unlocked <= 1'b1;
              fail_cnt <= '0;
              r_state  <= S_UNLOCKED;
            end else begin
              fail <= 1'b1;
              if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                locked_out <= 1'b1;
                fail_cnt   <= FW'(MAX_FAIL);
                r_state    <= S_LOCKOUT;
              end else begin
                if (fail_cnt != FW'(MAX_FAIL)) fail_cnt <= fail_cnt + FW'(1);
                r_state <= S_IDLE;
              end
            end
          end else if (bit_valid) begin
            r_idx   <= r_idx + IW'(1);
            r_mis   <= w_mis_all;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        // programming takes priority over relock and window expiry
        S_UNLOCKED: begin
          if (prog_req) begin
            r_pw     <= prog_pw;
            prog_ack <= 1'b1;
            unlocked <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_IDLE;
          end else if (relock || (r_timer == TW'(OPEN_CYCLES - 1))) begin
            unlocked <= 1'b0;
            r_timer  <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_LOCKOUT: begin
          if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            r_timer    <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lock_supervisor.md
Name: lock_supervisor

Overview:
Sequencing controller for the bit-serial password lock. It accepts strobed password bits MSB-first and compares them against a programmable password register. It also counts failed attempts, enforces a lockout window after repeated failures, and times out stalled entries. It holds the unlock output for a bounded window and allows the password to be re-programmed only while unlocked.

Parameters:
PW_LEN, 6, password length in bits
DEFAULT_PW, 6'b111000, password loaded on reset
MAX_FAIL, 3, consecutive failed attempts that trigger lockout
LOCKOUT_CYCLES, 16, lockout duration in clk cycles
OPEN_CYCLES, 8, maximum unlocked duration in clk cycles
TIMEOUT_CYCLES, 10, maximum idle gap between bits during an entry

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
bit_valid  in  1  bit_in is valid this cycle
bit_in  in  1  password bit, MSB first
relock  in  1  force relock while unlocked
prog_req  in  1  request to load prog_pw (honoured only while unlocked)
prog_pw  in  PW_LEN  new password value
unlocked  out  1  lock open
locked_out  out  1  lockout active
entry_busy  out  1  partial entry in progress
fail  out  1  one-cycle pulse per failed or timed-out attempt
prog_ack  out  1  one-cycle pulse when the password is written
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, pw_reg=DEFAULT_PW, bit index=0, mismatch flag=0, all timers=0, all outputs=0.
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT.
- IDLE:
  - bit_valid: compare bit_in with pw_reg[PW_LEN-1]; set mismatch flag; set index=1; go to ENTRY.
  - entry_busy=1 from the next cycle.
- ENTRY:
  - Each bit_valid compares bit_in with pw_reg[PW_LEN-1-index] and ORs the result into the mismatch flag.
  - A mismatch never aborts early. Exactly PW_LEN bits are always consumed, so the position of a wrong bit is not revealed.
- Evaluation, on the cycle the PW_LEN-th bit is accepted. Outputs are visible the next cycle.
  - Match: go to UNLOCKED, unlocked=1, fail_cnt=0.
  - Mismatch: pulse fail=1, then:
    - if fail_cnt+1 == MAX_FAIL: go to LOCKOUT, locked_out=1, fail_cnt=MAX_FAIL;
    - otherwise: fail_cnt increments, go to IDLE.
- Timeout:
  - In ENTRY, a gap counter resets on every accepted bit and increments otherwise.
  - When it reaches TIMEOUT_CYCLES with no bit_valid, the attempt is treated as a mismatch evaluation (fail pulse, fail_cnt/lockout rules apply).
  - bit_valid on that same cycle is accepted and the timeout is cancelled.
- UNLOCKED:
  - unlocked=1 for OPEN_CYCLES cycles, then IDLE.
  - relock returns to IDLE next cycle.
  - prog_req: pw_reg<=prog_pw, prog_ack pulses for one cycle, go to IDLE. The new password applies from the next entry.
  - prog_req together with relock: programming wins, with the same result as prog_req alone.
  - bit_valid is ignored.
- LOCKOUT:
  - locked_out=1 for LOCKOUT_CYCLES cycles.
  - bit_valid, relock and prog_req are ignored.
  - On exit: IDLE, fail_cnt=0, locked_out=0.
- prog_req outside UNLOCKED is ignored; prog_ack stays 0.
- fail_cnt saturates at MAX_FAIL and clears on success or on lockout exit.
- Reset asserted mid-entry, mid-unlock or mid-lockout returns everything to reset values on the next edge, including pw_reg=DEFAULT_PW.
- Index and timers are sized $clog2 of their limits. There is no wrap: each counter stops at its terminal value.

Test Plan:
- Correct entry: after reset, strobe 1,1,1,0,0,0 back-to-back → unlocked=1 on the cycle after the 6th bit, for exactly 8 cycles, then 0; fail never pulses.
- Wrong bit, position hidden: send 0,1,1,0,0,0 → no early abort, entry_busy=1 through the 6th bit; fail pulses once after it; fail_cnt=1; unlocked stays 0.
- Lockout: three wrong entries → fail_cnt goes 1, 2, then locked_out=1 for 16 cycles; a correct entry sent during lockout is ignored; afterwards fail_cnt=0 and a correct entry unlocks.
- Timeout vs bit: send 3 bits, then idle 10 cycles → fail pulse, fail_cnt=1, IDLE. Repeat with the 4th bit arriving on exactly the 10th gap cycle → bit accepted, no fail.
- Program: unlock, then assert prog_req with prog_pw=6'b101010 and relock in the same cycle → prog_ack pulses, state IDLE; 111000 now fails and 101010 unlocks.
- Reset mid-entry after programming: enter 2 bits, assert reset → all outputs 0, fail_cnt=0, and 111000 unlocks again.
